// File: rtl/dmem_responder_pkg.sv
// Shared constants and request/response records for the data-memory responder.
package dmem_responder_pkg;

  localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;
  localparam int          DEF_DEPTH_LOG2  = 12;
  localparam int          DEF_WAIT_STATES = 0;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_in_type;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } mem_out_type;

endpackage

// File: rtl/dmem_responder_ram.sv
// Single-port, byte-enabled, synchronous-read word storage (no reset on contents).
module dmem_ram #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  i_en,
  input  logic [3:0]            i_we,
  input  logic [DEPTH_LOG2-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic [31:0]           o_rdata
);

  logic [31:0] r_mem [2**DEPTH_LOG2];
  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++)
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      r_q <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_q;

endmodule

// File: rtl/dmem_responder.sv
// Memory-bus responder: accept, optional wait states, one SRAM access, one-cycle response.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR,
  parameter int          DEPTH_LOG2  = DEF_DEPTH_LOG2,
  parameter int          WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error
);

  localparam logic [3:0] WS4 = 4'(WAIT_STATES);

  mem_in_type  w_req;
  mem_out_type w_rsp;

  assign w_req = '{valid: mem_valid, instr: mem_instr, addr: mem_addr,
                   wdata: mem_wdata, wstrb: mem_wstrb};

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic [29:0] r_word;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_instr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req.valid) begin
          r_cnt   <= WS4;
          r_state <= (WS4 != 4'd0) ? ST_WAIT : ST_ACCESS;
        end
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt <= 4'd1) r_state <= ST_ACCESS;
        end
        ST_ACCESS: r_state <= ST_RESP;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  // Request fields only matter once accepted, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == ST_IDLE && w_req.valid) begin
      r_word  <= w_req.addr[31:2];
      r_wdata <= w_req.wdata;
      r_wstrb <= w_req.wstrb;
      r_instr <= w_req.instr;
    end
  end

  // Byte offset bits are meaningless for a word-wide memory.
  logic w_unused;
  assign w_unused = &{1'b0, w_req.addr[1:0]};

  // Unsigned wrap makes addresses below the base fall out of range.
  logic [29:0] w_off;
  logic        w_in_range;
  logic        w_err;
  logic        w_is_write;
  logic        w_do_access;
  logic [31:0] w_ram_q;

  assign w_off       = r_word - BASE_ADDR[31:2];
  assign w_in_range  = (w_off >> DEPTH_LOG2) == '0;
  assign w_is_write  = r_wstrb != 4'b0;
  assign w_err       = !w_in_range || (r_instr && w_is_write);
  // Reset in the ACCESS cycle suppresses the operation entirely.
  assign w_do_access = (r_state == ST_ACCESS) && !rst && !w_err;

  dmem_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clk    (clk),
    .i_en   (w_do_access),
    .i_we   (w_is_write ? r_wstrb : 4'b0),
    .i_addr (w_off[DEPTH_LOG2-1:0]),
    .i_wdata(r_wdata),
    .o_rdata(w_ram_q)
  );

  always_comb begin
    w_rsp.ready = (r_state == ST_RESP);
    w_rsp.error = w_rsp.ready && w_err;
    w_rsp.rdata = (w_rsp.ready && !w_err && !w_is_write) ? w_ram_q : '0;
  end

  assign mem_ready = w_rsp.ready;
  assign mem_rdata = w_rsp.rdata;
  assign mem_error = w_rsp.error;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder over four parameter sets (u0..u3).
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst [4];
  logic        vld [4];
  logic        instr;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        rdy [4];
  logic [31:0] rdata [4];
  logic        err [4];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst[0]), .mem_valid(vld[0]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[0]), .mem_rdata(rdata[0]), .mem_error(err[0]));
  dmem_responder #(.WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst[1]), .mem_valid(vld[1]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[1]), .mem_rdata(rdata[1]), .mem_error(err[1]));
  dmem_responder #(.BASE_ADDR(32'h0000_1000), .DEPTH_LOG2(4)) u2 (
    .clk(clk), .rst(rst[2]), .mem_valid(vld[2]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[2]), .mem_rdata(rdata[2]), .mem_error(err[2]));
  dmem_responder #(.WAIT_STATES(2)) u3 (
    .clk(clk), .rst(rst[3]), .mem_valid(vld[3]), .mem_instr(instr), .mem_addr(addr),
    .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_ready(rdy[3]), .mem_rdata(rdata[3]), .mem_error(err[3]));

  // lat = index of the edge (after the accept edge) at which the initiator samples ready; -1 on timeout.
  task automatic txn(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                     input logic ins, output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    addr = a; wdata = wd; wstrb = ws; instr = ins; vld[d] = 1'b1;
    @(posedge clk);
    lat = -1; rd = 'x; er = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rdy[d]) begin lat = i; rd = rdata[d]; er = err[d]; break; end
    end
    vld[d] = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    for (int i = 0; i < 4; i++) begin rst[i] = 1'b1; vld[i] = 1'b0; end
    instr = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    vld[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      total++; if (rdy[i] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=0", i, rdy[i]); end
      total++; if (rdata[i] !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h exp=0", i, rdata[i]); end
      total++; if (err[i] !== 1'b0) begin bad++; $display("FAIL reset_error[%0d] got=%b exp=0", i, err[i]); end
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    vld[0] = 1'b0;
    n = 0;
    repeat (6) begin @(negedge clk); if (rdy[0]) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL valid_in_reset_accepted got=%0d pulses exp=0", n); end
  endtask

  task automatic test_write_read;
    logic [31:0] rd; logic er; int lat;
    txn(0, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL wr_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'h0 || er !== 1'b0) begin bad++; $display("FAIL wr_resp got=%h/%b exp=0/0", rd, er); end
    txn(0, 32'h10, 32'h0, 4'h0, 1'b0, rd, er, lat);
    total++; if (lat !== 2) begin bad++; $display("FAIL rd_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDEADBEEF || er !== 1'b0) begin bad++; $display("FAIL rd_data got=%h/%b exp=deadbeef/0", rd, er); end
    txn(0, 32'h13, 32'h0, 4'h0, 1'b0, rd, er, lat);
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_unaligned got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_partial;
    logic [31:0] rd; logic er; int lat;
    txn(0, 32'h20, 32'h11223344, 4'hF, 1'b0, rd, er, lat);
    txn(0, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, rd, er, lat);
    txn(0, 32'h20, 32'h0, 4'h0, 1'b0, rd, er, lat);
    total++; if (rd !== 32'h11BB33DD) begin bad++; $display("FAIL partial_write got=%h exp=11bb33dd", rd); end
  endtask

  task automatic test_instr;
    logic [31:0] rd; logic er; int lat;
    txn(0, 32'h8, 32'h12345678, 4'hF, 1'b0, rd, er, lat);
    txn(0, 32'h8, 32'hFFFFFFFF, 4'hF, 1'b1, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL instr_write got=%h/%b exp=0/1", rd, er); end
    txn(0, 32'h8, 32'h0, 4'h0, 1'b1, rd, er, lat);
    total++; if (er !== 1'b0 || rd !== 32'h12345678) begin bad++; $display("FAIL instr_fetch got=%h/%b exp=12345678/0", rd, er); end
  endtask

  task automatic test_wait_states;
    logic [31:0] rd; logic er; int lat; int n;
    txn(1, 32'h0, 32'h0, 4'h0, 1'b0, rd, er, lat);
    total++; if (lat !== 5) begin bad++; $display("FAIL ws3_latency got=%0d exp=5", lat); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL ws3_error got=%b exp=0", er); end
    n = 0;
    repeat (8) begin @(negedge clk); if (rdy[1]) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL ws3_extra_ready got=%0d exp=0", n); end
  endtask

  task automatic test_range;
    logic [31:0] rd; logic er; int lat;
    for (int i = 0; i < 16; i++)
      txn(2, 32'h1000 + 4*i, 32'hC0DE0000 | i, 4'hF, 1'b0, rd, er, lat);
    txn(2, 32'h1040, 32'h0, 4'h0, 1'b0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL range_hi_read got=%h/%b exp=0/1", rd, er); end
    txn(2, 32'h0FFC, 32'h0, 4'h0, 1'b0, rd, er, lat);
    total++; if (er !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL range_lo_read got=%h/%b exp=0/1", rd, er); end
    txn(2, 32'h1040, 32'hFFFFFFFF, 4'hF, 1'b0, rd, er, lat);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL range_write_err got=%b exp=1", er); end
    for (int i = 0; i < 16; i++) begin
      txn(2, 32'h1000 + 4*i, 32'h0, 4'h0, 1'b0, rd, er, lat);
      total++;
      if (rd !== (32'hC0DE0000 | i) || er !== 1'b0) begin
        bad++; $display("FAIL range_word[%0d] got=%h/%b exp=%h/0", i, rd, er, 32'hC0DE0000 | i);
      end
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] rd; logic er; int lat; int n;
    txn(3, 32'h4, 32'hAAAA0000, 4'hF, 1'b0, rd, er, lat);
    @(negedge clk);
    addr = 32'h4; wdata = 32'h55; wstrb = 4'hF; instr = 1'b0; vld[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[3] = 1'b1; vld[3] = 1'b0;
    @(negedge clk);
    rst[3] = 1'b0;
    n = 0;
    repeat (6) begin @(negedge clk); if (rdy[3]) n++; end
    total++; if (n !== 0) begin bad++; $display("FAIL abort_ready got=%0d exp=0", n); end
    txn(3, 32'h4, 32'h0, 4'h0, 1'b0, rd, er, lat);
    total++; if (rd !== 32'hAAAA0000) begin bad++; $display("FAIL abort_no_write got=%h exp=aaaa0000", rd); end
    txn(3, 32'h4, 32'h55, 4'hF, 1'b0, rd, er, lat);
    total++; if (lat !== 4 || er !== 1'b0) begin bad++; $display("FAIL after_abort_wr got=lat%0d/%b exp=lat4/0", lat, er); end
    txn(3, 32'h4, 32'h0, 4'h0, 1'b0, rd, er, lat);
    total++; if (rd !== 32'h55) begin bad++; $display("FAIL after_abort_rd got=%h exp=00000055", rd); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial();
    test_instr();
    test_wait_states();
    test_range();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-002 Parameter DEPTH_LOG2, default 12, gives 2**DEPTH_LOG2 32-bit words.
REQ-003 Parameter WAIT_STATES, default 0, gives extra cycles inserted before the memory access (0..15).
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 mem_valid  in  1  request present; held with all request fields stable until mem_ready.
REQ-007 mem_instr  in  1  request is an instruction fetch.
REQ-008 mem_addr  in  32  byte address; bits [1:0] ignored.
REQ-009 mem_wdata  in  32  write data, lane-aligned by the initiator.
REQ-010 mem_wstrb  in  4  byte-write enables; 0 means read.
REQ-011 mem_ready  out  1  one-cycle response strobe.
REQ-012 mem_rdata  out  32  read data, valid only while mem_ready=1, otherwise 0.
REQ-013 mem_error  out  1  access fault, valid only while mem_ready=1.

Function
REQ-014 The FSM SHALL have four states: IDLE, WAIT, ACCESS, RESP.
REQ-015 In IDLE with mem_valid=1, the block SHALL latch addr, wdata, wstrb and instr, load the wait counter with WAIT_STATES, and go to WAIT if WAIT_STATES>0, else to ACCESS.
REQ-016 In WAIT, the counter SHALL decrement each cycle; the FSM goes to ACCESS when the counter reaches 1.
REQ-017 In ACCESS, the block SHALL issue exactly one SRAM operation from the latched request, then go to RESP.
- Write: only the byte lanes with wstrb=1 are updated.
- Read: synchronous read.
REQ-018 In RESP, the block SHALL drive mem_ready=1, mem_rdata and mem_error for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be 2+WAIT_STATES cycles from the accept edge to mem_ready=1.
REQ-020 A new request SHALL be accepted no earlier than the cycle after RESP; mem_valid outside IDLE is ignored.
REQ-021 A request SHALL be in range when (addr-BASE_ADDR)>>2 < 2**DEPTH_LOG2; the subtraction is unsigned 32-bit, so an address below BASE_ADDR wraps and is out of range.
REQ-022 Out of range: no SRAM write, mem_rdata=0, mem_error=1.
REQ-023 A request with mem_instr=1 and wstrb≠0 SHALL give mem_error=1, with no write and rdata=0.
REQ-024 A write response SHALL return mem_rdata=0 and mem_error=0.
REQ-025 A read SHALL return the whole word regardless of addr[1:0]; the initiator extracts bytes and halfwords.
REQ-026 A read that follows a write to the same word SHALL return the newly written data.

Reset
REQ-027 While rst=1 at a clock edge:
- FSM goes to IDLE and the counter clears.
- mem_ready=0, mem_rdata=0, mem_error=0.
REQ-028 Reset asserted in IDLE, WAIT or ACCESS-before-edge SHALL abort the request; a write not yet performed in ACCESS is never performed.
REQ-029 SRAM contents SHALL NOT be cleared by reset.
REQ-030 A mem_valid asserted during the reset cycle SHALL NOT be accepted; acceptance starts the first cycle after rst falls.

Structure
REQ-031 The state enumeration and the default parameter constants SHALL reside in the shared constants package.
REQ-032 The request/response port groups SHALL map onto the existing mem_in_type/mem_out_type records in wires.
REQ-033 One sub-module, dmem_ram, SHALL hold the storage: single-port, byte-enabled, synchronous-read.
REQ-034 The FSM, counter and range check SHALL remain in dmem_responder.

Verification
REQ-035 WAIT_STATES=0: write 0xDEADBEEF to 0x10 with wstrb=4'hF, then read 0x10 -> each mem_ready at accept+2; read returns 0xDEADBEEF, mem_error=0.
REQ-036 Partial write: word 0x20 holds 0x11223344; write wdata=0xAABBCCDD, wstrb=4'b0101; read 0x20 -> 0x11BB33DD.
REQ-037 WAIT_STATES=3: read 0x0 -> mem_ready exactly 5 cycles after accept, high for one cycle only; mem_valid held throughout causes no second accept until after RESP.
REQ-038 DEPTH_LOG2=4, BASE_ADDR=0x1000: read 0x1040 and read 0x0FFC -> mem_error=1, rdata=0; write 0x1040 leaves all 16 words unchanged.
REQ-039 mem_instr=1, wstrb=4'hF to 0x8 -> mem_error=1; a subsequent read of 0x8 shows the old value.
REQ-040 Write 0x55 to 0x4 with rst pulsed in WAIT (WAIT_STATES=2) -> no mem_ready; a read of 0x4 afterwards returns the pre-write value; the next request completes normally.
